// File: rtl/nco_pkg.sv
// nco_pkg
//   Shared definitions for the NCO phase controller: default widths, the
//   quarter-wave address offset that turns a cosine address into a sine
//   address, and the tuning-word update state encoding.
package nco_pkg;

  localparam int ACC_W_DEF   = 32;
  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 16;
  localparam int ROM_LAT_DEF = 1;

  // Tuning-word update state: IDLE accepts a new word, PEND holds one that
  // waits for the next accumulator wrap (or a phase clear).
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } upd_state_t;

  // Quarter of the ROM depth, i.e. pi/2 expressed in address units.
  function automatic int quarter_off(input int addr_w);
    return 1 << (addr_w - 2);
  endfunction

endpackage

// File: rtl/nco_valid_delay.sv
// nco_valid_delay
//   Shift register that carries the sample-valid tag alongside the ROM read
//   so that it emerges in step with the registered ROM data.
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset, clears every stage
//   in_vld   valid tag entering the pipe
//   out_vld  valid tag after LEN cycles
module nco_valid_delay #(
  parameter int LEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in_vld,
  output logic out_vld
);

  logic [LEN-1:0] vld_p;

  // Shifting with << keeps this legal for LEN == 1 as well.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p <= (vld_p << 1) | LEN'(in_vld);
    end
  end

  assign out_vld = vld_p[LEN-1];

endmodule

// File: rtl/nco_phase_ctrl.sv
// nco_phase_ctrl
//   NCO front end: phase accumulator, registered cos/sin ROM addresses and
//   capture of the ROM read data into aligned, valid-tagged samples.
//   Tuning words arrive over a valid/ready handshake; with SYNC_UPDATE=1 a
//   new word is held until the accumulator wraps so the phase stays
//   continuous.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   en                     advance accumulator and issue ROM reads
//   phase_clr              force accumulator to zero
//   phase_off              static phase offset added before truncation
//   ftw/ftw_valid/ftw_ready  tuning-word handshake
//   cos_addr, sin_addr     registered ROM addresses
//   cos_rom_data, sin_rom_data  ROM read data (ROM_LAT cycles after address)
//   out_valid, cos_out, sin_out  aligned sample strobe and data
module nco_phase_ctrl
  import nco_pkg::*;
#(
  parameter int ACC_W       = ACC_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ROM_LAT     = ROM_LAT_DEF,
  parameter int SYNC_UPDATE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     phase_clr,
  input  logic [ACC_W-1:0]         phase_off,
  input  logic [ACC_W-1:0]         ftw,
  input  logic                     ftw_valid,
  output logic                     ftw_ready,
  output logic [ADDR_W-1:0]        cos_addr,
  output logic [ADDR_W-1:0]        sin_addr,
  input  logic signed [DATA_W-1:0] cos_rom_data,
  input  logic signed [DATA_W-1:0] sin_rom_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] cos_out,
  output logic signed [DATA_W-1:0] sin_out
);

  localparam logic [ADDR_W-1:0] QUARTER = ADDR_W'(quarter_off(ADDR_W));

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  ftw_active;
  logic [ACC_W:0]    acc_sum;
  logic              wrap;
  logic              accept;
  logic [ADDR_W-1:0] cos_addr_next;
  logic              vld_last;

  // The extra top bit of acc_sum is the wrap (carry-out) indicator.
  assign acc_sum       = {1'b0, acc} + {1'b0, ftw_active};
  assign wrap          = en & acc_sum[ACC_W];
  assign accept        = ftw_valid & ftw_ready;
  assign cos_addr_next = ADDR_W'((acc + phase_off) >> (ACC_W - ADDR_W));

  // ---- p0: phase accumulator ----
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (phase_clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_sum[ACC_W-1:0];
    end
  end

  // Tuning-word update path
  generate
    if (SYNC_UPDATE != 0) begin : g_sync
      upd_state_t       state;
      logic [ACC_W-1:0] ftw_pend;

      // A phase clear coinciding with an accept, or arriving while a word is
      // pending, applies that word on the same edge as the clear.
      always_ff @(posedge clk) begin
        if (reset) begin
          state      <= IDLE;
          ftw_active <= '0;
          ftw_ready  <= 1'b1;
        end else begin
          case (state)
            IDLE: begin
              if (accept) begin
                if (phase_clr) begin
                  ftw_active <= ftw;
                end else begin
                  ftw_pend  <= ftw;
                  state     <= PEND;
                  ftw_ready <= 1'b0;
                end
              end
            end
            PEND: begin
              if (phase_clr || wrap) begin
                ftw_active <= ftw_pend;
                state      <= IDLE;
                ftw_ready  <= 1'b1;
              end
            end
          endcase
        end
      end
    end else begin : g_imm
      always_ff @(posedge clk) begin
        if (reset) begin
          ftw_active <= '0;
        end else if (accept) begin
          ftw_active <= ftw;
        end
      end

      assign ftw_ready = 1'b1;
    end
  endgenerate

  // ---- p1: ROM address registers (sin x = cos(x - pi/2)) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      cos_addr <= '0;
      sin_addr <= '0;
    end else if (en) begin
      cos_addr <= cos_addr_next;
      sin_addr <= cos_addr_next - QUARTER;
    end
  end

  // Valid tag: one stage for the address register plus ROM_LAT for the ROM.
  nco_valid_delay #(
    .LEN(ROM_LAT + 1)
  ) u_vld_delay (
    .clk    (clk),
    .reset  (reset),
    .in_vld (en),
    .out_vld(vld_last)
  );

  // ---- p2: sample capture ----
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      cos_out   <= '0;
      sin_out   <= '0;
    end else begin
      out_valid <= vld_last;
      if (vld_last) begin
        cos_out <= cos_rom_data;
        sin_out <= sin_rom_data;
      end
    end
  end

endmodule

// File: tb/tb_nco_phase_ctrl.sv
// tb_nco_phase_ctrl
//   Drives one immediate-update and one phase-continuous instance from the
//   same stimulus, with a registered ROM model behind each, and compares
//   addresses, handshake and output samples against a behavioural model and
//   a per-instance sample scoreboard.
module tb_nco_phase_ctrl;

  typedef struct {
    int          due;
    logic [15:0] c;
    logic [15:0] s;
  } samp_t;

  logic        clk = 1'b0;
  logic        reset, en, phase_clr, ftw_valid;
  logic [31:0] phase_off, ftw;

  logic        ftw_ready_o[2];
  logic [11:0] caddr_o[2], saddr_o[2];
  logic [15:0] crom[2], srom[2], cout_o[2], sout_o[2];
  logic        oval_o[2];

  // Behavioural model state per instance (0: immediate, 1: phase-continuous)
  logic [31:0] m_acc[2], m_act[2], m_pend[2];
  bit          m_pf[2], m_rdy[2];
  logic [11:0] m_ca[2], m_sa[2];
  logic [15:0] m_co[2], m_so[2];
  samp_t       q0[$], q1[$];

  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  obs;

  always #5 clk = ~clk;

  function automatic logic [15:0] romf(input logic [11:0] a);
    return {a[3:0], a} ^ 16'h5A3C;
  endfunction

  always_ff @(posedge clk) begin
    crom[0] <= romf(caddr_o[0]);
    srom[0] <= romf(saddr_o[0]);
    crom[1] <= romf(caddr_o[1]);
    srom[1] <= romf(saddr_o[1]);
  end

  nco_phase_ctrl #(.SYNC_UPDATE(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .phase_clr(phase_clr),
    .phase_off(phase_off), .ftw(ftw), .ftw_valid(ftw_valid),
    .ftw_ready(ftw_ready_o[0]), .cos_addr(caddr_o[0]), .sin_addr(saddr_o[0]),
    .cos_rom_data(crom[0]), .sin_rom_data(srom[0]),
    .out_valid(oval_o[0]), .cos_out(cout_o[0]), .sin_out(sout_o[0])
  );

  nco_phase_ctrl #(.SYNC_UPDATE(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .phase_clr(phase_clr),
    .phase_off(phase_off), .ftw(ftw), .ftw_valid(ftw_valid),
    .ftw_ready(ftw_ready_o[1]), .cos_addr(caddr_o[1]), .sin_addr(saddr_o[1]),
    .cos_rom_data(crom[1]), .sin_rom_data(srom[1]),
    .out_valid(oval_o[1]), .cos_out(cout_o[1]), .sin_out(sout_o[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Advance the model of instance i across the coming clock edge.
  task automatic model_edge(input int i);
    logic [32:0] sum;
    logic [31:0] p;
    logic        acc_ok;
    samp_t       e;
    if (reset) begin
      m_acc[i] = '0; m_act[i] = '0; m_pf[i] = 0; m_rdy[i] = 1;
      m_ca[i] = '0; m_sa[i] = '0; m_co[i] = '0; m_so[i] = '0;
      if (i == 0) q0.delete(); else q1.delete();
      return;
    end
    sum    = {1'b0, m_acc[i]} + {1'b0, m_act[i]};
    acc_ok = m_rdy[i] && ftw_valid;
    if (en) begin
      p = m_acc[i] + phase_off;
      m_ca[i] = p[31:20];
      m_sa[i] = p[31:20] - 12'h400;
      e.due = cyc + 3;
      e.c = romf(m_ca[i]);
      e.s = romf(m_sa[i]);
      if (i == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (phase_clr) m_acc[i] = '0;
    else if (en) m_acc[i] = sum[31:0];
    if (i == 0) begin
      if (acc_ok) m_act[i] = ftw;
    end else if (m_pf[i]) begin
      if (phase_clr || (en && sum[32])) begin
        m_act[i] = m_pend[i]; m_pf[i] = 0; m_rdy[i] = 1;
      end
    end else if (acc_ok) begin
      if (phase_clr) m_act[i] = ftw;
      else begin
        m_pend[i] = ftw; m_pf[i] = 1; m_rdy[i] = 0;
      end
    end
  endtask

  task automatic compare(input int i);
    samp_t e;
    logic  exp_v;
    exp_v = 1'b0;
    if (i == 0) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); exp_v = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); exp_v = 1'b1; end
    end
    if (exp_v) begin m_co[i] = e.c; m_so[i] = e.s; end
    check_val($sformatf("u%0d_ready", i), 32'(ftw_ready_o[i]), 32'(m_rdy[i]));
    check_val($sformatf("u%0d_cos_addr", i), 32'(caddr_o[i]), 32'(m_ca[i]));
    check_val($sformatf("u%0d_sin_addr", i), 32'(saddr_o[i]), 32'(m_sa[i]));
    check_val($sformatf("u%0d_out_valid", i), 32'(oval_o[i]), 32'(exp_v));
    check_val($sformatf("u%0d_cos_out", i), 32'(cout_o[i]), 32'(m_co[i]));
    check_val($sformatf("u%0d_sin_out", i), 32'(sout_o[i]), 32'(m_so[i]));
  endtask

  task automatic step();
    for (int i = 0; i < 2; i++) model_edge(i);
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) compare(i);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; phase_clr = 1'b0; ftw_valid = 1'b0;
    ftw = '0; phase_off = '0;
    repeat (2) step();
    for (int i = 0; i < 2; i++) begin
      check_val("rst_ready", 32'(ftw_ready_o[i]), 32'd1);
      check_val("rst_out_valid", 32'(oval_o[i]), 32'd0);
      check_val("rst_cos_addr", 32'(caddr_o[i]), 32'd0);
    end
    reset = 1'b0;

    // Immediate update, stepping one address per sample
    ftw = 32'h0010_0000; ftw_valid = 1'b1; step();
    ftw_valid = 1'b0; step();
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check_val("t1_cos_addr", 32'(caddr_o[0]), 32'(k));
      check_val("t1_sin_addr", 32'(saddr_o[0]), 32'h0000_0C00 + 32'(k));
      if (k < 2) check_val("t1_latency_lo", 32'(oval_o[0]), 32'd0);
      if (k == 2) check_val("t1_latency_hi", 32'(oval_o[0]), 32'd1);
    end

    // Half-rate tone with a quarter-turn offset
    en = 1'b0; reset = 1'b1; step(); reset = 1'b0;
    ftw = 32'h8000_0000; ftw_valid = 1'b1; phase_clr = 1'b1;
    phase_off = 32'h4000_0000; step();
    ftw_valid = 1'b0; phase_clr = 1'b0; en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        check_val("t2_cos_addr", 32'(caddr_o[i]), (k % 2) ? 32'h0C00 : 32'h0400);
        check_val("t2_sin_addr", 32'(saddr_o[i]), (k % 2) ? 32'h0800 : 32'h0000);
      end
    end

    // Phase-continuous update held until the wrap
    en = 1'b0; reset = 1'b1; step(); reset = 1'b0; phase_off = '0;
    ftw = 32'h4000_0000; ftw_valid = 1'b1; phase_clr = 1'b1; step();
    phase_clr = 1'b0; ftw = 32'h2000_0000; en = 1'b1; step();
    ftw_valid = 1'b0;
    check_val("t3_accept_ready", 32'(ftw_ready_o[1]), 32'd0);
    check_val("t3_accept_addr", 32'(caddr_o[1]), 32'h000);
    begin
      logic [11:0] a_exp[6] = '{12'h400, 12'h800, 12'hC00, 12'h000, 12'h200, 12'h400};
      bit          r_exp[6] = '{0, 0, 1, 1, 1, 1};
      for (int k = 0; k < 6; k++) begin
        step();
        check_val("t3_cos_addr", 32'(caddr_o[1]), 32'(a_exp[k]));
        check_val("t3_ready", 32'(ftw_ready_o[1]), 32'(r_exp[k]));
      end
    end

    // Phase clear applies a pending word at once
    ftw = 32'h1000_0000; ftw_valid = 1'b1; step();
    ftw_valid = 1'b0;
    check_val("t4_pend_ready", 32'(ftw_ready_o[1]), 32'd0);
    step(); step();
    phase_clr = 1'b1; step(); phase_clr = 1'b0;
    check_val("t4_clr_ready", 32'(ftw_ready_o[1]), 32'd1);
    check_val("t4_inflight", 32'(oval_o[1]), 32'd1);
    step(); check_val("t4_cos_addr0", 32'(caddr_o[1]), 32'h000);
    step(); check_val("t4_cos_addr1", 32'(caddr_o[1]), 32'h100);

    // Gapped enable pattern
    en = 1'b0; repeat (4) step();
    for (int s = 0; s < 8; s++) begin
      en = (s == 0 || s == 2 || s == 3);
      step();
      obs[s] = oval_o[0];
    end
    check_val("t5_valid_pattern", 32'(obs), 32'h34);

    // Reset mid-run with a pending word
    en = 1'b1; ftw = 32'h3000_0000; ftw_valid = 1'b1; step();
    ftw_valid = 1'b0; step();
    check_val("t6_pend_ready", 32'(ftw_ready_o[1]), 32'd0);
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_val("t6_ready", 32'(ftw_ready_o[i]), 32'd1);
      check_val("t6_cos_addr", 32'(caddr_o[i]), 32'd0);
      check_val("t6_sin_addr", 32'(saddr_o[i]), 32'd0);
      check_val("t6_out_valid", 32'(oval_o[i]), 32'd0);
      check_val("t6_cos_out", 32'(cout_o[i]), 32'd0);
      check_val("t6_sin_out", 32'(sout_o[i]), 32'd0);
    end
    step(); check_val("t6_quiet1", 32'(oval_o[1]), 32'd0);
    step(); check_val("t6_quiet2", 32'(oval_o[1]), 32'd0);
    step(); check_val("t6_first", 32'(oval_o[1]), 32'd1);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      reset     = ($urandom_range(0, 99) < 2);
      en        = ($urandom_range(0, 3) != 0);
      phase_clr = ($urandom_range(0, 19) == 0);
      ftw_valid = ($urandom_range(0, 2) == 0);
      ftw       = $urandom;
      if ($urandom_range(0, 9) == 0) phase_off = $urandom;
      step();
    end
    reset = 1'b0; en = 1'b0; phase_clr = 1'b0; ftw_valid = 1'b0;
    repeat (4) step();
    check_val("drain_u0", 32'(q0.size()), 32'd0);
    check_val("drain_u1", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
